pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- if_ready  in  1  fetch of current pc completes this cycle
- stall  in  1  hazard stall, holds pc
- exc_req  in  1  exception redirect request
- eret_req  in  1  return-from-exception request
- epc  in  30  eret target [31:2]
- jr_req  in  1  register-jump request
- reg_index  in  32  jr target byte address
- j_req  in  1  absolute jump request
- instr_index  in  26  jump index [27:2]
- br_req  in  1  taken-branch request
- id_pc  in  30  pc of the branch/jump in ID [31:2]
- offset  in  16  branch word offset [17:2]
- pc  out  30  fetch pc [31:2]
- flush_if  out  1  discard the instruction fetched this cycle
- pend_busy  out  1  latched redirect waiting

Function
REQ-003 Targets, modulo 2^30:
- exc -> 30'h00001060
- eret -> epc
- jr -> reg_index[31:2]
- j -> {id_pc[29:26], instr_index}
- br -> id_pc + sign-extended offset
REQ-004 Priority SHALL be exc > eret > jr > j > br; exactly one target is selected per cycle.
REQ-005 exc and eret are class A; jr, j and br are class B.
REQ-006 Advance condition SHALL be if_ready for class A and if_ready & ~stall for class B and sequential fetch.
REQ-007 The FSM SHALL have two states, RUN and PEND; reset state is RUN.
REQ-008 RUN, no request, advance true -> pc <= pc+1 at the next edge; advance false -> pc holds.
REQ-009 RUN, request, advance true -> pc <= target at the next edge and the FSM stays in RUN.
REQ-010 RUN, request, advance false -> target and class are latched in pend_pc/pend_cls, the FSM goes to PEND, and pc holds.
REQ-011 In PEND, pend_busy SHALL be 1; new requests are evaluated every cycle:
- higher-class request (A over latched B) -> overwrites pend_pc/pend_cls
- equal or lower class -> ignored
REQ-012 PEND, advance true for the latched class (or for the overwriting class in that cycle) -> pc <= pend_pc or the new target, FSM -> RUN.
REQ-013 flush_if SHALL be combinational and equal 1 in the cycle a redirect is applied (REQ-009/012); class-B behaviour is per REQ-017.
REQ-014 pc wrap-around at 30'h3FFFFFFF SHALL go to 0 with no flag.

Reset
REQ-015 On rst assertion, regardless of the clock, the block SHALL set:
- pc = 30'h00000C00
- state = RUN
- pend_pc = 0
- pend_cls = B
- pend_busy = 0
- flush_if = 0
REQ-016 Reset asserted while in PEND SHALL discard the latched redirect; the first cycle after release behaves as RUN with no history.

Configuration
REQ-017 Macro DELAY_SLOT_EN:
- defined -> class-B redirects do not assert flush_if (delay slot executes); class A still flushes.
- undefined -> every applied redirect asserts flush_if.

Verification
REQ-018 Reset release, if_ready=1, stall=0, no requests for 3 cycles -> pc 0C00, 0C01, 0C02, 0C03.
REQ-019 br_req with id_pc=0C04, offset=16'hFFFE, if_ready=1 -> next pc=0C02; flush_if=1 only when DELAY_SLOT_EN is undefined.
REQ-020 exc_req and jr_req together, reg_index=32'h00003010 -> next pc=1060, flush_if=1.
REQ-021 j_req with instr_index=26'h0000C10 while stall=1 for 2 cycles:
- pend_busy=1, pc held
- stall drops -> pc=0C10, pend_busy=0
REQ-022 Latched br in PEND, then exc_req while if_ready=0, then if_ready=1 -> pc=1060 (overwrite); a later eret with epc=0C20 -> pc=0C20.
REQ-023 rst asserted mid-PEND -> pc=0C00 immediately, pend_busy=0; the latched target is never applied.

Source files
------------

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-PC redirect bus: redirect requests and their targets in, fetch pc and flush/pending status out.
// master drives the requests (pipeline side); slave is the redirect controller.
interface pc_redirect_ctrl_if;
    logic        if_ready;
    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [29:0] epc;
    logic        jr_req;
    logic [31:0] reg_index;
    logic        j_req;
    logic [25:0] instr_index;
    logic        br_req;
    logic [29:0] id_pc;
    logic [15:0] offset;
    logic [29:0] pc;
    logic        flush_if;
    logic        pend_busy;

    modport master (
        output if_ready, stall, exc_req, eret_req, epc, jr_req, reg_index,
               j_req, instr_index, br_req, id_pc, offset,
        input  pc, flush_if, pend_busy
    );

    modport slave (
        input  if_ready, stall, exc_req, eret_req, epc, jr_req, reg_index,
               j_req, instr_index, br_req, id_pc, offset,
        output pc, flush_if, pend_busy
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer with prioritised redirects; redirects that cannot advance are held in PEND.
// Optional macro DELAY_SLOT_EN: class-B (jr/j/br) redirects leave the delay slot unflushed.
module pc_redirect_ctrl (
    input  logic               clk,
    input  logic               rst,
    pc_redirect_ctrl_if.slave  bus
);
    localparam logic [0:0]  RUN      = 1'b0;
    localparam logic [0:0]  PEND     = 1'b1;
    localparam logic        CLS_A    = 1'b1;
    localparam logic        CLS_B    = 1'b0;
    localparam logic [29:0] EXC_VEC  = 30'h00001060;
    localparam logic [29:0] RESET_PC = 30'h00000C00;

    logic [0:0]  state_reg, state_next;
    logic [29:0] pc_reg, pc_next;
    logic [29:0] pend_pc_reg, pend_pc_next;
    logic        pend_cls_reg, pend_cls_next;

    logic        req_a, req_any;
    logic [29:0] new_tgt;
    logic [29:0] br_tgt;
    logic        new_cls;
    logic        sel_valid, sel_cls, sel_adv, seq_adv, apply;
    logic [29:0] sel_pc;
    logic        unused_reg_index_lsbs;

    assign unused_reg_index_lsbs = ^bus.reg_index[1:0];

    assign req_a   = bus.exc_req | bus.eret_req;
    assign req_any = req_a | bus.jr_req | bus.j_req | bus.br_req;
    assign new_cls = req_a ? CLS_A : CLS_B;
    assign br_tgt  = bus.id_pc + {{14{bus.offset[15]}}, bus.offset};

    always_comb begin
        new_tgt = br_tgt;
        if (bus.exc_req)       new_tgt = EXC_VEC;
        else if (bus.eret_req) new_tgt = bus.epc;
        else if (bus.jr_req)   new_tgt = bus.reg_index[31:2];
        else if (bus.j_req)    new_tgt = {bus.id_pc[29:26], bus.instr_index};
    end

    // In PEND only a class-A request may displace a latched class-B redirect.
    always_comb begin
        sel_valid = req_any;
        sel_pc    = new_tgt;
        sel_cls   = new_cls;
        if (state_reg == PEND) begin
            sel_valid = 1'b1;
            if (!(req_a && pend_cls_reg == CLS_B)) begin
                sel_pc  = pend_pc_reg;
                sel_cls = pend_cls_reg;
            end
        end
    end

    assign seq_adv = bus.if_ready & ~bus.stall;
    assign sel_adv = (sel_cls == CLS_A) ? bus.if_ready : seq_adv;
    assign apply   = sel_valid & sel_adv;

`ifdef DELAY_SLOT_EN
    assign bus.flush_if = apply & (sel_cls == CLS_A) & ~rst;
`else
    assign bus.flush_if = apply & ~rst;
`endif

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pend_pc_next  = pend_pc_reg;
        pend_cls_next = pend_cls_reg;
        if (apply) begin
            pc_next    = sel_pc;
            state_next = RUN;
        end else if (sel_valid) begin
            state_next    = PEND;
            pend_pc_next  = sel_pc;
            pend_cls_next = sel_cls;
        end else if (seq_adv) begin
            pc_next = pc_reg + 30'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_PC;
            pend_pc_reg  <= '0;
            pend_cls_reg <= CLS_B;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pend_pc_reg  <= pend_pc_next;
            pend_cls_reg <= pend_cls_next;
        end
    end

    assign bus.pc        = pc_reg;
    assign bus.pend_busy = (state_reg == PEND);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: a driver computes expected outputs from a behavioural
// model and queues them; a monitor on the falling edge pops and compares against the DUT.
module tb_pc_redirect_ctrl;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    typedef struct packed {
        int          cyc;
        logic [29:0] pc;
        logic        busy;
        logic        flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // reference model state: fetch pc and an optional parked redirect
    logic [29:0] m_pc     = 30'h00000C00;
    bit          m_pend   = 1'b0;
    logic [29:0] m_ptgt   = '0;
    bit          m_pcls_a = 1'b0;

    task automatic clear_reqs();
        bus.exc_req = 0; bus.eret_req = 0; bus.jr_req = 0; bus.j_req = 0; bus.br_req = 0;
    endtask

    // Called with this cycle's inputs already applied; queues expected outputs, advances model.
    task automatic tick();
        exp_t        e;
        bit          have, a, cand, cand_a, go;
        logic [29:0] t, cand_t, sx;
        e.cyc = cyc; e.pc = m_pc; e.busy = m_pend; e.flush = 1'b0;
        if (rst) begin
            m_pc = 30'h00000C00; m_pend = 0;
            e.pc = 30'h00000C00; e.busy = 0;
        end else begin
            have = 1; a = 0; t = '0;
            sx = {{14{bus.offset[15]}}, bus.offset};
            if (bus.exc_req)       begin t = 30'h00001060; a = 1; end
            else if (bus.eret_req) begin t = bus.epc; a = 1; end
            else if (bus.jr_req)   t = bus.reg_index[31:2];
            else if (bus.j_req)    t = {bus.id_pc[29:26], bus.instr_index};
            else if (bus.br_req)   t = bus.id_pc + sx;
            else                   have = 0;
            cand = have; cand_t = t; cand_a = a;
            if (m_pend) begin
                cand = 1;
                if (!(have && a && !m_pcls_a)) begin cand_t = m_ptgt; cand_a = m_pcls_a; end
            end
            go = cand_a ? bus.if_ready : (bus.if_ready && !bus.stall);
            if (cand && go) begin
                e.flush = cand_a || !DS;
                m_pc = cand_t; m_pend = 0;
            end else if (cand) begin
                m_pend = 1; m_ptgt = cand_t; m_pcls_a = cand_a;
            end else if (bus.if_ready && !bus.stall) begin
                m_pc = m_pc + 30'd1;
            end
        end
        q.push_back(e);
        @(posedge clk); #2;
        cyc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks += 3;
            if (bus.pc !== e.pc) begin
                n_fail++; $display("FAIL pc cyc %0d: got %h want %h", e.cyc, bus.pc, e.pc);
            end
            if (bus.pend_busy !== e.busy) begin
                n_fail++; $display("FAIL pend_busy cyc %0d: got %b want %b", e.cyc, bus.pend_busy, e.busy);
            end
            if (bus.flush_if !== e.flush) begin
                n_fail++; $display("FAIL flush_if cyc %0d: got %b want %b", e.cyc, bus.flush_if, e.flush);
            end
            $display("cyc %0d pc=%h busy=%b flush=%b", e.cyc, bus.pc, bus.pend_busy, bus.flush_if);
        end
    end

    initial begin
        bus.if_ready = 1; bus.stall = 0; bus.epc = '0; bus.reg_index = '0;
        bus.instr_index = '0; bus.id_pc = '0; bus.offset = '0;
        clear_reqs();
        @(posedge clk); #2;
        tick(); tick();
        rst = 0;
        // sequential fetch from reset
        repeat (4) tick();
        // taken branch backwards
        bus.br_req = 1; bus.id_pc = 30'h0C04; bus.offset = 16'hFFFE; tick();
        clear_reqs(); tick();
        // exception beats register jump
        bus.exc_req = 1; bus.jr_req = 1; bus.reg_index = 32'h00003010; tick();
        clear_reqs(); tick();
        // jump parked by stall, applied when stall drops
        bus.id_pc = 30'h0; bus.instr_index = 26'h0000C10; bus.j_req = 1; bus.stall = 1; tick();
        clear_reqs(); tick();
        bus.stall = 0; tick(); tick();
        // parked branch overwritten by exception, then eret
        bus.br_req = 1; bus.id_pc = 30'h0C40; bus.offset = 16'h0008; bus.stall = 1; tick();
        clear_reqs(); bus.exc_req = 1; bus.if_ready = 0; tick();
        clear_reqs(); tick();
        bus.if_ready = 1; tick();
        bus.stall = 0; bus.eret_req = 1; bus.epc = 30'h0C20; tick();
        clear_reqs(); tick();
        // reset while a redirect is parked
        bus.jr_req = 1; bus.reg_index = 32'h0000_8000; bus.stall = 1; tick();
        clear_reqs(); tick();
        rst = 1; tick();
        rst = 0; bus.stall = 0; tick(); tick();
        // wrap-around
        bus.jr_req = 1; bus.reg_index = 32'hFFFF_FFFC; tick();
        clear_reqs(); tick(); tick();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.if_ready   = ($urandom_range(0, 3) != 0);
            bus.stall      = ($urandom_range(0, 2) == 0);
            bus.exc_req    = ($urandom_range(0, 15) == 0);
            bus.eret_req   = ($urandom_range(0, 11) == 0);
            bus.jr_req     = ($urandom_range(0, 9) == 0);
            bus.j_req      = ($urandom_range(0, 9) == 0);
            bus.br_req     = ($urandom_range(0, 5) == 0);
            bus.epc        = 30'($urandom);
            bus.reg_index  = $urandom;
            bus.instr_index = 26'($urandom);
            bus.id_pc      = 30'($urandom);
            bus.offset     = 16'($urandom);
            tick();
        end
        rst = 0; clear_reqs();
        repeat (2) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL drain: got %0d entries left want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
